pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RISC-V cores. It replaces the fixed 32-bit load-always PC register with a sequenced PC that supports stall, redirect, trap and return. It sits at the front of fetch and drives the instruction-memory word address and the current PC to decode and execute. A one-entry pending-redirect buffer keeps redirects that arrive during a stall.

## Interface
- XLEN, 32, PC and target width in bits.
- IMEM_AW, 8, instruction-memory word-address width; must satisfy IMEM_AW+2 <= XLEN.
- RESET_VEC, 0, PC value loaded at reset (XLEN bits, word-aligned).
- TRAP_VEC, 32'h0000_0040, PC value loaded on trap entry (word-aligned).

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the PC this cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  branch/jump target.
- trap_req  in  1  exception/interrupt entry request.
- mret_req  in  1  return from trap.
- pc_o  out  XLEN  current PC, registered.
- pc_plus4_o  out  XLEN  pc_o + 4, modulo 2^XLEN.
- imem_addr_o  out  IMEM_AW  pc_o[IMEM_AW+1:2].
- epc_o  out  XLEN  saved exception PC, registered.
- fetch_valid_o  out  1  pc_o is a valid fetch address this cycle.
- misalign_o  out  1  one-cycle pulse: the last applied redirect target had bits [1:0] != 0.

## Operation
- FSM states:
  - BOOT: entered on reset; fetch_valid_o=0; always moves to RUN on the next clk edge; the PC holds RESET_VEC.
  - RUN: fetch_valid_o=1; the PC updates every edge.
- Next-PC priority in RUN, evaluated each edge:
  - trap_req: pc<=TRAP_VEC; epc<=pc_o; clears pending redirect.
  - mret_req: pc<=epc_o; clears pending.
  - stall=1: pc holds. If redirect_valid, latch the target into the pending buffer; a newer redirect overwrites the older one.
  - pending set (stall=0): pc<=pending target; clear pending. A simultaneous redirect_valid wins over pending and pending is cleared.
  - redirect_valid: pc<=redirect_target.
  - else: pc<=pc_o+4.
- trap_req and mret_req override stall.
- trap_req and mret_req together: trap wins; epc is overwritten with pc_o.
- Inputs in BOOT are ignored, except that a redirect is ignored (not buffered).
- Arithmetic: pc+4 wraps at 2^XLEN (0xFFFF_FFFC -> 0x0000_0000 for XLEN=32). imem_addr_o wraps naturally through truncation.
- Misaligned target handling: see Configuration.

## Timing
- Reset (rst low, asynchronous) values: pc_o=RESET_VEC, epc_o=0, state=BOOT, fetch_valid_o=0, misalign_o=0, pending=empty.
- Output derivation:
  - pc_plus4_o and imem_addr_o are combinational from the pc register.
  - All other outputs are registered.
- Latency:
  - A redirect, trap or mret sampled at edge N is visible on pc_o after edge N.
  - A buffered redirect is applied at the first edge with stall=0.
- Reset asserted mid-stall drops the pending redirect and returns the FSM to BOOT.
- After rst deasserts, the first valid fetch of RESET_VEC occurs in the cycle after the first clk edge.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect or pending target with bits [1:0] != 0 is not applied.
  - Instead pc<=TRAP_VEC, epc<=pc_o, and misalign_o pulses for one cycle.
  - An mret target is forced aligned.
- PC_MISALIGN_TRAP_EN undefined:
  - Target bits [1:0] are forced to 0 silently.
  - misalign_o is tied to 0.

## Structure
- Shared package pc_pkg holds:
  - FSM state enum {BOOT, RUN}.
  - PC_INC constant (4).
  - Default RESET_VEC/TRAP_VEC constants, shared with the CSR block.
- One sub-module, pc_redirect_buf: the one-entry pending-redirect register, with load (stall & redirect_valid), clear, valid flag and target.
- The FSM and next-PC mux stay in pc_unit.

## Test plan
- Reset release: rst low->high with defaults -> first cycle fetch_valid_o=0, pc_o=0; then pc_o=0,4,8 on successive edges; imem_addr_o=0,1,2.
- Redirect: redirect_valid=1, target=0x80 at PC 0x10 -> next pc_o=0x80, then 0x84.
- Stall buffering: stall=1 for 3 cycles, with redirects to 0x20 then 0x30 during the stall:
  - pc_o holds throughout.
  - At the first stall=0 edge, pc_o=0x30.
- Trap/mret:
  - trap_req at PC 0x24 with stall=1 -> pc_o=0x40, epc_o=0x24.
  - Later mret_req -> pc_o=0x24.
  - trap_req+mret_req together -> pc_o=0x40.
- Wrap: PC 0xFFFF_FFFC with no events -> next pc_o=0x0000_0000, and pc_plus4_o=0 beforehand.
- Misalign:
  - With PC_MISALIGN_TRAP_EN, redirect to 0x82 -> pc_o=0x40, misalign_o pulse, epc_o=old PC.
  - Without the macro -> pc_o=0x80, misalign_o=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit and the CSR block.
package pc_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0040;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect register: holds a redirect that arrived while fetch was stalled.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_target,
  output logic            valid,
  output logic [XLEN-1:0] target
);

  // Clear has priority; the top never asserts both in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      target <= load_target;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Sequenced program counter with stall, redirect, trap and mret.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being aligned.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     IMEM_AW   = 8,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  input  logic               trap_req,
  input  logic               mret_req,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pc_plus4_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [XLEN-1:0]    epc_o,
  output logic               fetch_valid_o,
  output logic               misalign_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  if (IMEM_AW + 2 > XLEN) begin : g_bad_aw
    $error("pc_unit: IMEM_AW+2 must not exceed XLEN");
  end

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_d, epc_d;
  logic [XLEN-1:0] buf_target, sel_target;
  logic            buf_valid, buf_load, buf_clear;
  logic            fetch_valid_d, misalign_d;

  assign pc_plus4_o  = pc_o + XLEN'(PC_INC);
  assign imem_addr_o = pc_o[IMEM_AW+1:2];
  // A live redirect beats an older buffered one.
  assign sel_target  = redirect_valid ? redirect_target : buf_target;

  pc_redirect_buf #(
    .XLEN(XLEN)
  ) u_redirect_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_target(redirect_target),
    .valid      (buf_valid),
    .target     (buf_target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_o          <= RESET_VEC;
      epc_o         <= '0;
      fetch_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_o          <= pc_d;
      epc_o         <= epc_d;
      fetch_valid_o <= fetch_valid_d;
      misalign_o    <= misalign_d;
    end
  end

  // Next-state and next-PC priority: trap, mret, stall, redirect/pending, sequential.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_o;
    epc_d         = epc_o;
    misalign_d    = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    fetch_valid_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_req) begin
          pc_d      = TRAP_VEC;
          epc_d     = pc_o;
          buf_clear = 1'b1;
        end else if (mret_req) begin
          pc_d      = epc_o & ALIGN_MASK;
          buf_clear = 1'b1;
        end else if (stall) begin
          buf_load  = redirect_valid;
        end else if (redirect_valid || buf_valid) begin
          buf_clear = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
          if (sel_target[1:0] != 2'b00) begin
            pc_d       = TRAP_VEC;
            epc_d      = pc_o;
            misalign_d = 1'b1;
          end else begin
            pc_d       = sel_target;
          end
`else
          pc_d = sel_target & ALIGN_MASK;
`endif
        end else begin
          pc_d = pc_plus4_o;
        end
      end
      default: state_d = BOOT;
    endcase
    fetch_valid_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a behavioural reference model checked every cycle.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid, trap_req, mret_req;
  logic [31:0] redirect_target;
  logic [31:0] pc_o, pc_plus4_o, epc_o;
  logic [7:0]  imem_addr_o;
  logic        fetch_valid_o, misalign_o;

  int total = 0;
  int bad   = 0;

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_req       (trap_req),
    .mret_req       (mret_req),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .imem_addr_o    (imem_addr_o),
    .epc_o          (epc_o),
    .fetch_valid_o  (fetch_valid_o),
    .misalign_o     (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural PC behaviour written directly from the rules.
  logic [31:0] m_pc, m_epc, m_pend_t, t;
  logic        m_run, m_pend, m_mis;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = RV; m_epc = 0; m_run = 0; m_pend = 0; m_pend_t = 0; m_mis = 0;
    end else begin
      m_mis = 0;
      if (!m_run) begin
        m_run = 1;
      end else if (trap_req) begin
        m_epc = m_pc; m_pc = TV; m_pend = 0;
      end else if (mret_req) begin
        m_pc = m_epc - (m_epc % 4); m_pend = 0;
      end else if (stall) begin
        if (redirect_valid) begin m_pend = 1; m_pend_t = redirect_target; end
      end else if (redirect_valid || m_pend) begin
        t = redirect_valid ? redirect_target : m_pend_t;
        m_pend = 0;
`ifdef PC_MISALIGN_TRAP_EN
        if (t % 4 != 0) begin m_epc = m_pc; m_pc = TV; m_mis = 1; end
        else m_pc = t;
`else
        m_pc = t - (t % 4);
`endif
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e_p4;
    e_p4 = m_pc + 32'd4;
    check("pc", pc_o, m_pc);
    check("pc_plus4", pc_plus4_o, e_p4);
    check("imem_addr", {24'd0, imem_addr_o}, (m_pc / 4) % 256);
    check("epc", epc_o, m_epc);
    check("fetch_valid", {31'd0, fetch_valid_o}, {31'd0, m_run});
    check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; stall = 0; redirect_valid = 0; trap_req = 0; mret_req = 0; redirect_target = 0;
    cyc(); cyc();
    check("rst_pc", pc_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_fv", {31'd0, fetch_valid_o}, 32'd0);
    check("rst_mis", {31'd0, misalign_o}, 32'd0);
    rst = 1'b1;
    check("boot_fv", {31'd0, fetch_valid_o}, 32'd0);
    cyc(); check("first_pc", pc_o, 32'h0); check("first_fv", {31'd0, fetch_valid_o}, 32'd1);
    check("first_imem", {24'd0, imem_addr_o}, 32'd0);
    cyc(); check("pc4", pc_o, 32'h4); check("imem1", {24'd0, imem_addr_o}, 32'd1);
    cyc(); check("pc8", pc_o, 32'h8); check("imem2", {24'd0, imem_addr_o}, 32'd2);
    cyc(); cyc(); check("pc10", pc_o, 32'h10);
    // Plain redirect
    redirect_valid = 1; redirect_target = 32'h80; cyc(); check("redir", pc_o, 32'h80);
    redirect_valid = 0; cyc(); check("redir_seq", pc_o, 32'h84);
    // Stall with two redirects: newest one applied afterwards
    stall = 1; redirect_valid = 1; redirect_target = 32'h20; cyc(); check("stall_hold1", pc_o, 32'h84);
    redirect_target = 32'h30; cyc(); check("stall_hold2", pc_o, 32'h84);
    redirect_valid = 0; cyc(); check("stall_hold3", pc_o, 32'h84);
    stall = 0; cyc(); check("pending_apply", pc_o, 32'h30);
    redirect_valid = 1; redirect_target = 32'h24; cyc(); redirect_valid = 0;
    // Trap overrides stall, then mret, then both together
    trap_req = 1; stall = 1; cyc(); check("trap_pc", pc_o, 32'h40); check("trap_epc", epc_o, 32'h24);
    trap_req = 0; stall = 0; cyc(); check("after_trap", pc_o, 32'h44);
    mret_req = 1; cyc(); check("mret_pc", pc_o, 32'h24);
    trap_req = 1; cyc(); check("trap_mret_pc", pc_o, 32'h40); check("trap_mret_epc", epc_o, 32'h24);
    trap_req = 0; mret_req = 0;
    // Trap clears a pending redirect
    stall = 1; redirect_valid = 1; redirect_target = 32'h100; cyc();
    redirect_valid = 0; trap_req = 1; cyc(); check("trap_clr_epc", epc_o, 32'h40);
    trap_req = 0; stall = 0; cyc(); check("trap_clr_pend", pc_o, 32'h44);
    // Live redirect beats pending and drops it
    stall = 1; redirect_valid = 1; redirect_target = 32'h200; cyc();
    stall = 0; redirect_target = 32'h300; cyc(); check("redir_beats_pend", pc_o, 32'h300);
    redirect_valid = 0; cyc(); check("pend_dropped", pc_o, 32'h304);
    // Wrap-around
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC; cyc(); redirect_valid = 0;
    check("wrap_plus4", pc_plus4_o, 32'h0); check("wrap_imem", {24'd0, imem_addr_o}, 32'hFF);
    cyc(); check("wrap_pc", pc_o, 32'h0);
    cyc();
    // Misaligned redirect
    redirect_valid = 1; redirect_target = 32'h82; cyc(); redirect_valid = 0;
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_pc", pc_o, 32'h40); check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    check("mis_epc", epc_o, 32'h4);
    cyc(); check("mis_pulse_end", {31'd0, misalign_o}, 32'd0); check("mis_next", pc_o, 32'h44);
`else
    check("mis_pc", pc_o, 32'h80); check("mis_pulse", {31'd0, misalign_o}, 32'd0);
    cyc(); check("mis_next", pc_o, 32'h84);
`endif
    // Misaligned pending target
    stall = 1; redirect_valid = 1; redirect_target = 32'h91; cyc();
    stall = 0; redirect_valid = 0; cyc(); cyc();
    // Reset during stall drops pending; BOOT ignores redirect and trap
    stall = 1; redirect_valid = 1; redirect_target = 32'h500; cyc();
    #1 rst = 1'b0; #1;
    check("midrst_pc", pc_o, RV); check("midrst_fv", {31'd0, fetch_valid_o}, 32'd0);
    rst = 1'b1; stall = 0; redirect_target = 32'h600; trap_req = 1;
    cyc(); check("boot_ignore_pc", pc_o, 32'h0); check("boot_ignore_epc", epc_o, 32'h0);
    redirect_valid = 0; trap_req = 0;
    cyc(); check("post_boot", pc_o, 32'h4);
    cyc(); cyc();
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
